load_store_unit: RTL

//  Multi-cycle data-memory access stage of the one-stage RV32I core; feeds the register file write port.

---
 rtl/rv_lsu_pkg.sv | 18 +
 rtl/lsu_align.sv | 57 +++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rv_lsu_pkg.sv
// Shared types for the load/store unit: RV32I load/store width codes and FSM states.
package rv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WB,
    DONE,
    ERR
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment check, store replicate/strobe, load select/extend.
module lsu_align
  import rv_lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Bring the addressed lane down to bit 0 so every width extends from the same place.
  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    legal     = 1'b0;
    wdata     = store_data;
    wstrb     = 4'b0000;
    load_data = shifted;
    case (funct3)
      F3_B: begin
        legal     = 1'b1;
        wdata     = {4{store_data[7:0]}};
        wstrb     = 4'b0001 << addr_lo;
        load_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        legal     = !addr_lo[0];
        wdata     = {2{store_data[15:0]}};
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        legal     = (addr_lo == 2'b00);
        wstrb     = 4'b1111;
        load_data = rdata;
      end
      F3_BU: begin
        legal     = !is_store;
        load_data = {24'd0, shifted[7:0]};
      end
      F3_HU: begin
        legal     = !is_store && !addr_lo[0];
        load_data = {16'd0, shifted[15:0]};
      end
      default: legal = 1'b0;
    endcase
    if (!is_store) wstrb = 4'b0000;
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: one command at a time, valid/ready memory transaction,
// aligned/extended load writeback pulse, error completion on illegal command or timeout.
module load_store_unit
  import rv_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic [31:0] data_write,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_t  state, state_nxt;
  logic        is_store_q;
  logic [2:0]  f3_q;
  logic [1:0]  addr_lo_q;
  logic [4:0]  rd_q;
  logic [CW-1:0] cnt;

  logic        idle;
  logic        timed_out;
  logic        a_store;
  logic [2:0]  a_f3;
  logic [1:0]  a_lo;
  logic        a_legal;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic [31:0] a_ldata;

  assign idle = (state == IDLE);
  assign busy = !idle;

  // One aligner serves both phases: live command while idle, latched command afterwards.
  assign a_store = idle ? is_store : is_store_q;
  assign a_f3    = idle ? funct3 : f3_q;
  assign a_lo    = idle ? addr[1:0] : addr_lo_q;

  // With TIMEOUT=0 this can never match since cnt+1 >= 1.
  assign timed_out = (32'(cnt) + 32'd1) == 32'(TIMEOUT);

  lsu_align u_align (
    .is_store   (a_store),
    .funct3     (a_f3),
    .addr_lo    (a_lo),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .legal      (a_legal),
    .wdata      (a_wdata),
    .wstrb      (a_wstrb),
    .load_data  (a_ldata)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = a_legal ? REQ : ERR;
      REQ: begin
        if (mem_ready)      state_nxt = is_store_q ? DONE : WB;
        else if (timed_out) state_nxt = ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      is_store_q <= 1'b0;
      f3_q       <= 3'd0;
      addr_lo_q  <= 2'd0;
      rd_q       <= 5'd0;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      rd         <= 5'd0;
      reg_write  <= 1'b0;
      data_write <= 32'd0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done      <= (state_nxt == WB) || (state_nxt == DONE) || (state_nxt == ERR);
      err       <= (state_nxt == ERR);
      reg_write <= (state_nxt == WB) && (rd_q != 5'd0);

      if (idle && start) begin
        is_store_q <= is_store;
        f3_q       <= funct3;
        addr_lo_q  <= addr[1:0];
        rd_q       <= rd_in;
        cnt        <= '0;
      end

      if (idle && state_nxt == REQ) begin
        mem_req   <= 1'b1;
        mem_we    <= is_store;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= a_wdata;
        mem_wstrb <= a_wstrb;
      end else if (state == REQ && state_nxt != REQ) begin
        mem_req <= 1'b0;
      end

      if (state == REQ && !mem_ready) cnt <= cnt + CW'(1);

      if (state == REQ && mem_ready && !is_store_q) begin
        rd         <= rd_q;
        data_write <= a_ldata;
      end
    end
  end

endmodule
